if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 128 ++++++++++++
 tb/tb_if_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: Wishbone read master with hold buffer and branch redirect
module if_fetch #(
  parameter logic [31:0] PC_ADDR    = 32'h8000_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic                    branch_taken_in,
  input  logic [ADDR_WIDTH-1:0]   branch_target_in,
  input  logic                    downstream_stall_in,
  output logic [ADDR_WIDTH-1:0]   pc_new_out,
  output logic [1:0]              stall_and_flush_out,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   inst_out,
  output logic [ADDR_WIDTH-1:0]   inst_pc_out,
  output logic                    inst_valid_out
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t                  r_state;
  logic                    r_redir_pending;
  logic [ADDR_WIDTH-1:0]   r_redir_pc;
  logic [DATA_WIDTH-1:0]   r_hold_buf;

  logic w_ack;
  logic w_discard;
  logic w_flush;
  logic w_advance;
  logic w_load;

  assign wb_sel_o = '1;
  assign wb_we_o  = 1'b0;

  assign w_ack     = (r_state == BUSY) && wb_ack_i;
  assign w_discard = w_ack && (r_redir_pending || branch_taken_in);
  // A branch outside BUSY also flushes: it drops any held word and refetches.
  assign w_flush   = w_discard || ((r_state != BUSY) && branch_taken_in);
  assign w_advance = w_discard || (w_ack && !downstream_stall_in) ||
                     ((r_state == HOLD) && !downstream_stall_in);
  assign w_load    = w_advance && !w_flush;

  always_comb begin
    stall_and_flush_out = 2'b01;
    if (!reset)
      stall_and_flush_out = 2'b01;
    else if (w_flush)
      stall_and_flush_out = 2'b10;
    else if (w_advance)
      stall_and_flush_out = 2'b00;
  end

  always_comb begin
    if (r_redir_pending)
      pc_new_out = r_redir_pc;
    else if (branch_taken_in)
      pc_new_out = branch_target_in;
    else
      pc_new_out = pc_in + ADDR_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_adr_o        <= ADDR_WIDTH'(PC_ADDR);
      r_redir_pending <= 1'b0;
      r_redir_pc      <= '0;
      r_hold_buf      <= '0;
      inst_out        <= DATA_WIDTH'(32'h0000_0013);
      inst_pc_out     <= ADDR_WIDTH'(PC_ADDR);
      inst_valid_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          wb_adr_o <= pc_in;
          if (!branch_taken_in) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (w_discard) begin
              r_redir_pending <= 1'b0;
              r_state         <= IDLE;
            end else if (downstream_stall_in) begin
              r_hold_buf <= wb_dat_i;
              r_state    <= HOLD;
            end else begin
              r_state <= IDLE;
            end
          end else if (branch_taken_in) begin
            // The bus cycle cannot be aborted, so remember where to go once it ends.
            r_redir_pending <= 1'b1;
            r_redir_pc      <= branch_target_in;
          end
        end
        HOLD: begin
          if (branch_taken_in || !downstream_stall_in)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        inst_out       <= (r_state == HOLD) ? r_hold_buf : wb_dat_i;
        inst_pc_out    <= wb_adr_o;
        inst_valid_out <= 1'b1;
      end else if (!downstream_stall_in) begin
        inst_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch against a transaction-level model
module tb_if_fetch;

  localparam logic [31:0] PC_ADDR = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        downstream_stall_in;
  logic [31:0] pc_new_out;
  logic [1:0]  stall_and_flush_out;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_i, inst_out, inst_pc_out;
  logic [3:0]  wb_sel_o;
  logic        inst_valid_out;

  if_fetch #(.PC_ADDR(PC_ADDR), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .downstream_stall_in(downstream_stall_in), .pc_new_out(pc_new_out),
    .stall_and_flush_out(stall_and_flush_out),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .inst_valid_out(inst_valid_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Environment PC register plus the reference view of the fetch unit.
  logic [31:0] pc;
  logic        m_busy;
  logic [31:0] m_adr;
  logic        m_redir_v;
  logic [31:0] m_redir_pc;
  logic [31:0] m_held[$];
  logic [31:0] m_inst, m_ipc;
  logic        m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_adr     = PC_ADDR;
    m_redir_v = 1'b0;
    m_redir_pc = '0;
    m_held.delete();
    m_inst    = 32'h0000_0013;
    m_ipc     = PC_ADDR;
    m_valid   = 1'b0;
    pc        = PC_ADDR;
  endtask

  task automatic step(input logic rn, input logic br, input logic [31:0] tgt,
                      input logic ds, input logic ack, input logic [31:0] dat);
    logic [31:0] e_pcn, word, old_adr;
    logic [1:0]  e_sf;
    logic        acked, disc, ld;
    @(negedge clk);
    reset = rn; branch_taken_in = br; branch_target_in = tgt;
    downstream_stall_in = ds; wb_ack_i = ack; wb_dat_i = dat; pc_in = pc;
    #1;
    e_pcn = m_redir_v ? m_redir_pc : (br ? tgt : pc + 32'd4);
    acked = m_busy && ack;
    disc  = acked && (m_redir_v || br);
    if (!rn)                                                  e_sf = 2'b01;
    else if (disc || (!m_busy && br))                         e_sf = 2'b10;
    else if ((acked && !ds) || (m_held.size() != 0 && !ds))   e_sf = 2'b00;
    else                                                      e_sf = 2'b01;

    check_eq("cyc", wb_cyc_o, m_busy);
    check_eq("stb", wb_stb_o, m_busy);
    check_eq("adr", wb_adr_o, m_adr);
    check_eq("inst", inst_out, m_inst);
    check_eq("inst_pc", inst_pc_out, m_ipc);
    check_eq("valid", inst_valid_out, m_valid);
    check_eq("sf", stall_and_flush_out, e_sf);
    check_eq("pc_new", pc_new_out, e_pcn);

    if (!rn) begin
      model_reset();
    end else begin
      ld = 1'b0; word = '0; old_adr = m_adr;
      if (m_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          if (disc) m_redir_v = 1'b0;
          else if (ds) m_held.push_back(dat);
          else begin ld = 1'b1; word = dat; end
        end else if (br) begin
          m_redir_v = 1'b1; m_redir_pc = tgt;
        end
      end else if (m_held.size() != 0) begin
        if (br) m_held.delete();
        else if (!ds) begin ld = 1'b1; word = m_held.pop_front(); end
      end else begin
        m_adr = pc;
        if (!br) m_busy = 1'b1;
      end
      if (ld) begin m_inst = word; m_ipc = old_adr; m_valid = 1'b1; end
      else if (!ds) m_valid = 1'b0;
      if (!e_sf[0]) pc = e_pcn;
    end
  endtask

  initial begin
    reset = 1'b0; pc_in = PC_ADDR; branch_taken_in = 1'b0; branch_target_in = '0;
    downstream_stall_in = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    model_reset();
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0, 0, 0);
    check_eq("rst_sf", stall_and_flush_out, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("rst_inst", inst_out, 32'h0000_0013);
    check_eq("rst_adr", wb_adr_o, PC_ADDR);
    check_eq("sel", wb_sel_o, 32'hF);
    check_eq("we", wb_we_o, 32'd0);

    // First fetch with same-cycle ack
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h0010_0093);
    check_eq("f1_adr", wb_adr_o, 32'h8000_0000);
    check_eq("f1_pcnew", pc_new_out, 32'h8000_0004);
    check_eq("f1_sf", stall_and_flush_out, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check_eq("f1_inst", inst_out, 32'h0010_0093);
    check_eq("f1_ipc", inst_pc_out, 32'h8000_0000);
    check_eq("f1_valid", inst_valid_out, 32'd1);

    // Ack delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check_eq("wait_sf", stall_and_flush_out, 32'd1);
      check_eq("wait_adr", wb_adr_o, 32'h8000_0004);
    end
    step(1, 0, 0, 0, 1, 32'h0020_0113);
    step(1, 0, 0, 0, 0, 0);

    // Downstream stall at ack -> HOLD
    step(1, 0, 0, 1, 1, 32'h0030_0193);
    check_eq("hold_sf", stall_and_flush_out, 32'd1);
    step(1, 0, 0, 1, 0, 0);
    check_eq("hold_cyc", wb_cyc_o, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check_eq("rel_sf", stall_and_flush_out, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check_eq("rel_inst", inst_out, 32'h0030_0193);
    check_eq("rel_ipc", inst_pc_out, 32'h8000_0008);

    // Branch mid-BUSY, ack two cycles later
    step(1, 1, 32'h8000_0100, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check_eq("disc_sf", stall_and_flush_out, 32'd2);
    check_eq("disc_pcnew", pc_new_out, 32'h8000_0100);
    step(1, 0, 0, 0, 0, 0);
    check_eq("disc_valid", inst_valid_out, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check_eq("redir_adr", wb_adr_o, 32'h8000_0100);
    step(1, 0, 0, 0, 1, 32'h0040_0213);

    // PC wrap
    pc = 32'hFFFF_FFFC;
    step(1, 0, 0, 0, 0, 0);
    check_eq("wrap_pcnew", pc_new_out, 32'h0000_0000);
    step(1, 0, 0, 0, 1, 32'h0050_0293);

    // Reset while BUSY, late ack ignored
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h0000_0BAD);
    step(1, 0, 0, 0, 0, 0);
    check_eq("rb_adr", wb_adr_o, PC_ADDR);
    check_eq("rb_cyc", wb_cyc_o, 32'd1);
    check_eq("rb_valid", inst_valid_out, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic        rn, br, ds, ack;
      logic [31:0] tgt, dat;
      rn  = ($urandom_range(0, 63) != 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      ds  = ($urandom_range(0, 2) == 0);
      ack = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      dat = $urandom;
      if ($urandom_range(0, 31) == 0)
        pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(rn, br, tgt, ds, ack, dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
